bram_port_arbiter: RTL and testbench

//  Shares one 1024x36 simple-dual-port BRAM (write port A, registered read port B) between two clients.

---
 rtl/bram_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 35 +++
 rtl/bram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-client BRAM port arbiter.
package bram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 36;

    // Client indices into the request/grant vectors
    localparam int C0 = 0;
    localparam int C1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins. Under contention
// the client named by the pointer wins, and the pointer then moves to the
// other client. The pointer only moves when a contended grant is accepted.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr_q;  // 0 favours C0, 1 favours C1

    // Grant selection: pointer only matters when both clients request
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt     = 2'b00;
            gnt[C0] = ~ptr_q;
            gnt[C1] = ptr_q;
        end
    end

    // Pointer moves to the loser after an accepted contended grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept && (req == 2'b11)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM (write port A, registered read port B)
// between two clients. After reset the array is zero-filled, then client
// writes go to port A and reads to port B, each through its own round-robin
// arbiter. Read data returns to the issuing client one cycle after handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | zero-filling the array (or waiting one clock if no clear)
//   ST_RUN  | arbitrating client requests; only reset leaves this state
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,

    input  logic              c0_req_valid,
    output logic              c0_req_ready,
    input  logic              c0_req_we,
    input  logic [ADDR_W-1:0] c0_req_addr,
    input  logic [DATA_W-1:0] c0_req_wdata,
    output logic              c0_rsp_valid,
    output logic [DATA_W-1:0] c0_rsp_data,

    input  logic              c1_req_valid,
    output logic              c1_req_ready,
    input  logic              c1_req_we,
    input  logic [ADDR_W-1:0] c1_req_addr,
    input  logic [DATA_W-1:0] c1_req_wdata,
    output logic              c1_rsp_valid,
    output logic [DATA_W-1:0] c1_rsp_data,

    output logic              ram_wen_A,
    output logic [ADDR_W-1:0] ram_addr_A,
    output logic [DATA_W-1:0] ram_din_A,
    output logic              ram_ren_B,
    output logic [ADDR_W-1:0] ram_addr_B,
    input  logic [DATA_W-1:0] ram_dout_B
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              armed_q;      // set on the first clock after reset release
    logic [ADDR_W:0]   init_cnt_q;
    logic              stall_q;      // a read was held off by a write last cycle
    logic              rsp_pend_q;
    logic              rsp_tag_q;    // owner of the in-flight read (0 = C0)

    logic              run;
    logic              init_wr;
    logic [1:0]        vld, we;
    logic [ADDR_W-1:0] addr_w, addr_r;
    logic [DATA_W-1:0] wdata_w;
    logic [1:0]        wr_req, rd_req, gnt_w, gnt_r, ready;
    logic              collide, issue_w, issue_r;

    assign run     = (state_q == ST_RUN);
    assign init_wr = (state_q == ST_INIT) && armed_q && INIT_CLEAR;

    assign vld = {c1_req_valid, c0_req_valid};
    assign we  = {c1_req_we, c0_req_we};

    // Writes are held off for one cycle after a stall so the stalled read can go
    assign wr_req = vld & we & {2{run & ~stall_q}};
    assign rd_req = vld & ~we & {2{run}};

    rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_req),
        .accept (issue_w),
        .gnt    (gnt_w)
    );

    rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rd_req),
        .accept (issue_r),
        .gnt    (gnt_r)
    );

    assign addr_w  = gnt_w[C1] ? c1_req_addr  : c0_req_addr;
    assign wdata_w = gnt_w[C1] ? c1_req_wdata : c0_req_wdata;
    assign addr_r  = gnt_r[C1] ? c1_req_addr  : c0_req_addr;

    // The RAM forwards din_A to dout_B whenever both ports fire, so a read may
    // only share a cycle with a write to the same address.
    assign collide = (|gnt_w) && (|gnt_r) && (addr_w != addr_r);
    assign issue_w = |gnt_w;
    assign issue_r = (|gnt_r) && !collide;
    assign ready   = (gnt_w & {2{issue_w}}) | (gnt_r & {2{issue_r}});

    // Next-state logic: INIT always ends in RUN, RUN is terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (!INIT_CLEAR) begin
                    state_d = ST_RUN;
                end else if (armed_q && (init_cnt_q == INIT_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State, init sweep counter, stall flag and read-response tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            armed_q    <= 1'b0;
            init_cnt_q <= '0;
            stall_q    <= 1'b0;
            rsp_pend_q <= 1'b0;
            rsp_tag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            if (init_wr) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            stall_q    <= collide;
            rsp_pend_q <= issue_r;
            rsp_tag_q  <= gnt_r[C1];
        end
    end

    // RAM port drive: the init sweep owns port A until RUN
    always_comb begin
        ram_wen_A  = 1'b0;
        ram_addr_A = addr_w;
        ram_din_A  = wdata_w;
        if (init_wr) begin
            ram_wen_A  = 1'b1;
            ram_addr_A = init_cnt_q[ADDR_W-1:0];
            ram_din_A  = '0;
        end else if (issue_w) begin
            ram_wen_A  = 1'b1;
        end
        ram_ren_B  = issue_r;
        ram_addr_B = addr_r;
    end

    assign init_done    = run;
    assign c0_req_ready = ready[C0];
    assign c1_req_ready = ready[C1];
    assign c0_rsp_valid = rsp_pend_q & ~rsp_tag_q;
    assign c1_rsp_valid = rsp_pend_q & rsp_tag_q;
    assign c0_rsp_data  = ram_dout_B;
    assign c1_rsp_data  = ram_dout_B;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed and randomised checks of bram_port_arbiter against a behavioural
// simple-dual-port RAM with write-to-read forwarding.
module tb_bram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic [1:0]    vld = '0, we = '0, rdy, rsp_v;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] rsp_d [2];
    logic          wen_a, ren_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, dout_b;
    logic [DW-1:0] ram [0:1023];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: port B forwards port A data whenever both fire
    always @(posedge clk) begin
        if (wen_a) ram[addr_a] <= din_a;
        if (ren_b) dout_b <= wen_a ? din_a : ram[addr_b];
    end

    bram_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .c0_req_valid (vld[0]),
        .c0_req_ready (rdy[0]),
        .c0_req_we    (we[0]),
        .c0_req_addr  (addr[0]),
        .c0_req_wdata (wd[0]),
        .c0_rsp_valid (rsp_v[0]),
        .c0_rsp_data  (rsp_d[0]),
        .c1_req_valid (vld[1]),
        .c1_req_ready (rdy[1]),
        .c1_req_we    (we[1]),
        .c1_req_addr  (addr[1]),
        .c1_req_wdata (wd[1]),
        .c1_rsp_valid (rsp_v[1]),
        .c1_rsp_data  (rsp_d[1]),
        .ram_wen_A    (wen_a),
        .ram_addr_A   (addr_a),
        .ram_din_A    (din_a),
        .ram_ren_B    (ren_b),
        .ram_addr_B   (addr_b),
        .ram_dout_B   (dout_b)
    );

    task automatic clear_reqs();
        vld = '0;
        we  = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
    endtask

    // Called just after a negedge with a request driven; returns on the
    // negedge following the handshake posedge.
    task automatic wait_accept(input int i, input string nm);
        int n = 0;
        #1;
        while (rdy[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (rdy[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s: ready=%b after %0d cycles, want 1", nm, rdy[i], n);
        end
        @(negedge clk);
    endtask

    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        vld[i] = 1'b1; we[i] = 1'b1; addr[i] = a; wd[i] = d;
        wait_accept(i, "write_accept");
        vld[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        vld[i] = 1'b1; we[i] = 1'b0; addr[i] = a;
        wait_accept(i, "read_accept");
        vld[i] = 1'b0;
        total++;
        if (rsp_v[i] !== 1'b1 || rsp_d[i] !== exp) begin
            bad++;
            $display("FAIL read_c%0d_%h: valid=%b data=%h, want 1 %h", i, a, rsp_v[i], rsp_d[i], exp);
        end
    endtask

    task automatic test_reset();
        int  n = 0;
        bit  ok = 1'b1;
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        total++;
        if ({init_done, rdy, rsp_v, wen_a, ren_b} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want 0000000", {init_done, rdy, rsp_v, wen_a, ren_b});
        end
        rst_n = 1'b1;
        while (wen_a !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 1024; k++) begin
            if (ok && (wen_a !== 1'b1 || addr_a !== AW'(k) || din_a !== '0 ||
                       init_done !== 1'b0 || rdy !== 2'b00)) begin
                $display("FAIL init_sweep: step %0d wen=%b addr=%0d din=%h done=%b, want 1 %0d 0 0",
                         k, wen_a, addr_a, din_a, init_done, k);
                ok = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) bad++;
        total++;
        if (init_done !== 1'b1 || wen_a !== 1'b0) begin
            bad++;
            $display("FAIL init_done_rise: done=%b wen=%b, want 1 0", init_done, wen_a);
        end
    endtask

    task automatic test_read_init();
        do_read(0, 10'h005, 36'h0);
    endtask

    task automatic test_write_rr();
        // both write together: pointer favours c0
        vld = 2'b11; we = 2'b11;
        addr[0] = 10'h003; wd[0] = 36'h1;
        addr[1] = 10'h004; wd[1] = 36'h2;
        #1;
        total++;
        if (rdy !== 2'b01 || addr_a !== 10'h003) begin
            bad++;
            $display("FAIL wr_rr_first: rdy=%b addr=%h, want 01 003", rdy, addr_a);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        #1;
        total++;
        if (rdy !== 2'b10 || addr_a !== 10'h004 || din_a !== 36'h2) begin
            bad++;
            $display("FAIL wr_rr_second: rdy=%b addr=%h din=%h, want 10 004 2", rdy, addr_a, din_a);
        end
        @(negedge clk);
        // repeat: pointer now at c1
        vld = 2'b11;
        #1;
        total++;
        if (rdy !== 2'b10) begin
            bad++;
            $display("FAIL wr_rr_repeat: rdy=%b, want 10", rdy);
        end
        @(negedge clk);
        vld[1] = 1'b0;
        #1;
        total++;
        if (rdy !== 2'b01) begin
            bad++;
            $display("FAIL wr_rr_repeat2: rdy=%b, want 01", rdy);
        end
        @(negedge clk);
        clear_reqs();
        do_read(0, 10'h003, 36'h1);
        do_read(1, 10'h004, 36'h2);
    endtask

    task automatic test_same_addr();
        vld = 2'b11; we = 2'b01;
        addr[0] = 10'h007; wd[0] = 36'hABC;
        addr[1] = 10'h007;
        #1;
        total++;
        if (rdy !== 2'b11 || wen_a !== 1'b1 || ren_b !== 1'b1) begin
            bad++;
            $display("FAIL same_addr_issue: rdy=%b wen=%b ren=%b, want 11 1 1", rdy, wen_a, ren_b);
        end
        @(negedge clk);
        clear_reqs();
        total++;
        if (rsp_v !== 2'b10 || rsp_d[1] !== 36'hABC) begin
            bad++;
            $display("FAIL same_addr_rsp: valid=%b data=%h, want 10 abc", rsp_v, rsp_d[1]);
        end
    endtask

    task automatic test_stall();
        do_write(0, 10'h009, 36'h55);
        vld = 2'b11; we = 2'b01;
        addr[0] = 10'h008; wd[0] = 36'h111;
        addr[1] = 10'h009;
        #1;
        total++;
        if (rdy !== 2'b01 || ren_b !== 1'b0 || wen_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_cycle: rdy=%b ren=%b wen=%b, want 01 0 1", rdy, ren_b, wen_a);
        end
        @(negedge clk);
        wd[0] = 36'h222;
        #1;
        total++;
        if (rdy !== 2'b10 || wen_a !== 1'b0 || ren_b !== 1'b1 || addr_b !== 10'h009) begin
            bad++;
            $display("FAIL stall_release: rdy=%b wen=%b ren=%b addr=%h, want 10 0 1 009",
                     rdy, wen_a, ren_b, addr_b);
        end
        @(negedge clk);
        vld[1] = 1'b0;
        total++;
        if (rsp_v !== 2'b10 || rsp_d[1] !== 36'h55) begin
            bad++;
            $display("FAIL stall_rsp: valid=%b data=%h, want 10 55", rsp_v, rsp_d[1]);
        end
        #1;
        total++;
        if (rdy[0] !== 1'b1 || wen_a !== 1'b1 || din_a !== 36'h222) begin
            bad++;
            $display("FAIL stall_write_resume: rdy0=%b wen=%b din=%h, want 1 1 222", rdy[0], wen_a, din_a);
        end
        @(negedge clk);
        clear_reqs();
        do_read(1, 10'h008, 36'h222);
    endtask

    task automatic test_fairness();
        int c0 = 0, c1 = 0;
        vld = 2'b11; we = 2'b11;
        addr[0] = 10'h200; wd[0] = 36'h7;
        addr[1] = 10'h201; wd[1] = 36'h8;
        for (int k = 0; k < 16; k++) begin
            #1;
            c0 += int'(rdy[0]);
            c1 += int'(rdy[1]);
            @(negedge clk);
        end
        total++;
        if (c0 != 8 || c1 != 8) begin
            bad++;
            $display("FAIL wr_fairness: c0=%0d c1=%0d, want 8 8", c0, c1);
        end
        c0 = 0; c1 = 0;
        we = 2'b00;
        for (int k = 0; k < 16; k++) begin
            #1;
            c0 += int'(rdy[0]);
            c1 += int'(rdy[1]);
            @(negedge clk);
        end
        total++;
        if (c0 != 8 || c1 != 8) begin
            bad++;
            $display("FAIL rd_fairness: c0=%0d c1=%0d, want 8 8", c0, c1);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int n = 0;
        vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h005;
        #1;
        total++;
        if (rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_accept: rdy0=%b, want 1", rdy[0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_reqs();
        #1;
        seen = rsp_v[0];
        repeat (3) begin
            @(negedge clk);
            seen = seen | rsp_v[0];
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_mid_rsp: rsp pulse seen=%b, want 0", seen);
        end
        total++;
        if (init_done !== 1'b0 || wen_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: done=%b wen=%b, want 0 0", init_done, wen_a);
        end
        rst_n = 1'b1;
        while (wen_a !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (wen_a !== 1'b1 || addr_a !== 10'h000 || rsp_v !== 2'b00) begin
            bad++;
            $display("FAIL reinit_start: wen=%b addr=%h rsp=%b, want 1 000 00", wen_a, addr_a, rsp_v);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL reinit_done: done=%b after %0d cycles, want 1", init_done, n);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] refm [16];
        bit            busy [2];
        bit            ev [2];
        logic [DW-1:0] ed [2];
        bit            wa;
        logic [AW-1:0] wad;
        logic [DW-1:0] wdt;
        int            done_n = 0, cyc = 0, rbad = 0;
        for (int k = 0; k < 16; k++) refm[k] = '0;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; ev[i] = 1'b0; ed[i] = '0;
        end
        while (done_n < 4096 && cyc < 30000) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (rsp_v[i] !== ev[i] || (ev[i] && rsp_d[i] !== ed[i])) begin
                    bad++;
                    if (rbad < 10)
                        $display("FAIL rand_rsp_c%0d: cyc %0d valid=%b data=%h, want %b %h",
                                 i, cyc, rsp_v[i], rsp_d[i], ev[i], ed[i]);
                    rbad++;
                end
                ev[i] = 1'b0;
                if (!busy[i] && $urandom_range(3, 0) != 0) begin
                    busy[i] = 1'b1;
                    vld[i]  = 1'b1;
                    we[i]   = 1'($urandom_range(1, 0));
                    addr[i] = AW'(32'h100 + $urandom_range(15, 0));
                    wd[i]   = {4'($urandom), $urandom};
                end else if (!busy[i]) begin
                    vld[i] = 1'b0;
                end
            end
            #1;
            wa = 1'b0; wad = '0; wdt = '0;
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && rdy[i] && we[i]) begin
                    wa = 1'b1; wad = addr[i]; wdt = wd[i];
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && rdy[i]) begin
                    if (!we[i]) begin
                        ev[i] = 1'b1;
                        ed[i] = (wa && wad == addr[i]) ? wdt : refm[addr[i][3:0]];
                    end
                    busy[i] = 1'b0;
                    done_n++;
                end
            end
            if (wa) refm[wad[3:0]] = wdt;
            @(negedge clk);
            cyc++;
        end
        clear_reqs();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rsp_v[i] !== ev[i] || (ev[i] && rsp_d[i] !== ed[i])) begin
                bad++;
                $display("FAIL rand_rsp_last_c%0d: valid=%b data=%h, want %b %h",
                         i, rsp_v[i], rsp_d[i], ev[i], ed[i]);
            end
        end
        total++;
        if (done_n < 4096) begin
            bad++;
            $display("FAIL rand_progress: accepted=%0d, want 4096", done_n);
        end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_read_init();
        test_write_rr();
        test_same_addr();
        test_stall();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
